// File: rtl/i2c_xfer_sequencer.sv
// Turns one EEPROM-style transfer descriptor into the byte command chain of the i2c_master core.
// Optional ACK polling on the device-write address: define I2C_ACK_RETRY_EN.
module i2c_xfer_sequencer #(
    parameter int ADDR_BYTES = 2,
    parameter int LEN_W      = 4,
    parameter int MAX_RETRY  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [7:0]       req_dev_addr,
    input  logic [15:0]      req_mem_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       wdata,
    output logic             wdata_ready,
    output logic [7:0]       rdata,
    output logic             rdata_valid,
    output logic             xfer_done,
    output logic             xfer_err,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_start,
    output logic             cmd_stop,
    output logic             cmd_rd,
    output logic             cmd_nack,
    output logic [7:0]       cmd_wdata,
    input  logic             core_done,
    input  logic             core_ack,
    input  logic [7:0]       core_rdata
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DEV_W = 3'd1;
    localparam logic [2:0] S_MADDR = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_DEV_R = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;
    localparam logic [2:0] S_STOP  = 3'd6;
    localparam logic [2:0] S_FIN   = 3'd7;

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef I2C_ACK_RETRY_EN
    localparam int RETRY_LIMIT = MAX_RETRY;
`else
    localparam int RETRY_LIMIT = 0;
`endif

    logic [2:0]         state_q, state_d;
    logic               busy_q, busy_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               cmd_start_q, cmd_start_d;
    logic               cmd_stop_q, cmd_stop_d;
    logic               cmd_rd_q, cmd_rd_d;
    logic               cmd_nack_q, cmd_nack_d;
    logic [7:0]         cmd_byte_q, cmd_byte_d;
    logic               rw_q, rw_d;
    logic [6:0]         dev_q, dev_d;
    logic [15:0]        mem_q, mem_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               abyte_q, abyte_d;
    logic               err_q, err_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               retry_pend_q, retry_pend_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               rdata_valid_q, rdata_valid_d;
    logic               launch;
    logic               last_d;
    logic               unused_dev_bit;

    assign unused_dev_bit = req_dev_addr[0];
    assign last_d = (cnt_d == LEN_W'(1));

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_start_d   = cmd_start_q;
        cmd_stop_d    = cmd_stop_q;
        cmd_rd_d      = cmd_rd_q;
        cmd_nack_d    = cmd_nack_q;
        cmd_byte_d    = cmd_byte_q;
        rw_d          = rw_q;
        dev_d         = dev_q;
        mem_d         = mem_q;
        cnt_d         = cnt_q;
        abyte_d       = abyte_q;
        err_d         = err_q;
        retry_d       = retry_q;
        retry_pend_d  = retry_pend_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        launch        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rw_d         = req_rw;
                    dev_d        = req_dev_addr[7:1];
                    mem_d        = req_mem_addr;
                    cnt_d        = (req_len == '0) ? LEN_W'(1) : req_len;
                    abyte_d      = 1'b0;
                    err_d        = 1'b0;
                    retry_d      = '0;
                    retry_pend_d = 1'b0;
                    state_d      = S_DEV_W;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: begin
                if (cmd_valid_q) begin
                    if (cmd_ready) begin
                        cmd_valid_d = 1'b0;
                        busy_d      = 1'b1;
                    end
                end else if (busy_q) begin
                    // The next command is loaded on the same edge that retires the current one.
                    if (core_done) begin
                        busy_d = 1'b0;
                        launch = 1'b1;
                        case (state_q)
                            S_DEV_W: begin
                                if (core_ack) begin
                                    state_d = S_MADDR;
                                end else begin
                                    state_d = S_STOP;
                                    if (int'(retry_q) < RETRY_LIMIT) begin
                                        retry_d      = retry_q + RETRY_W'(1);
                                        retry_pend_d = 1'b1;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                end
                            end
                            S_MADDR: begin
                                if (!core_ack) begin
                                    err_d   = 1'b1;
                                    state_d = S_STOP;
                                end else if ((ADDR_BYTES == 1) || abyte_q) begin
                                    abyte_d = 1'b0;
                                    state_d = rw_q ? S_DEV_R : S_WDATA;
                                end else begin
                                    abyte_d = 1'b1;
                                end
                            end
                            S_WDATA: begin
                                if (!core_ack) begin
                                    err_d   = 1'b1;
                                    state_d = S_STOP;
                                end else if (cnt_q == LEN_W'(1)) begin
                                    state_d = S_FIN;
                                end else begin
                                    cnt_d = cnt_q - LEN_W'(1);
                                end
                            end
                            S_DEV_R: begin
                                if (core_ack) begin
                                    state_d = S_RDATA;
                                end else begin
                                    err_d   = 1'b1;
                                    state_d = S_STOP;
                                end
                            end
                            S_RDATA: begin
                                rdata_valid_d = 1'b1;
                                rdata_d       = core_rdata;
                                if (cnt_q == LEN_W'(1)) begin
                                    state_d = S_FIN;
                                end else begin
                                    cnt_d = cnt_q - LEN_W'(1);
                                end
                            end
                            S_STOP: begin
                                retry_pend_d = 1'b0;
                                state_d      = retry_pend_q ? S_DEV_W : S_FIN;
                            end
                            default: state_d = S_FIN;
                        endcase
                    end
                end else begin
                    launch = 1'b1;
                end
            end
        endcase

        if (launch && (state_d != S_FIN)) begin
            cmd_valid_d = 1'b1;
            cmd_start_d = (state_d == S_DEV_W) || (state_d == S_DEV_R);
            cmd_rd_d    = (state_d == S_RDATA);
            cmd_stop_d  = (state_d == S_STOP) ||
                          (((state_d == S_WDATA) || (state_d == S_RDATA)) && last_d);
            cmd_nack_d  = (state_d == S_RDATA) && last_d;
            case (state_d)
                S_DEV_W: cmd_byte_d = {dev_q, 1'b0};
                S_MADDR: cmd_byte_d = ((ADDR_BYTES > 1) && !abyte_d) ? mem_q[15:8] : mem_q[7:0];
                S_DEV_R: cmd_byte_d = {dev_q, 1'b1};
                default: cmd_byte_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_start_q   <= 1'b0;
            cmd_stop_q    <= 1'b0;
            cmd_rd_q      <= 1'b0;
            cmd_nack_q    <= 1'b0;
            cmd_byte_q    <= 8'h00;
            rw_q          <= 1'b0;
            dev_q         <= 7'h00;
            mem_q         <= 16'h0000;
            cnt_q         <= '0;
            abyte_q       <= 1'b0;
            err_q         <= 1'b0;
            retry_q       <= '0;
            retry_pend_q  <= 1'b0;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_start_q   <= cmd_start_d;
            cmd_stop_q    <= cmd_stop_d;
            cmd_rd_q      <= cmd_rd_d;
            cmd_nack_q    <= cmd_nack_d;
            cmd_byte_q    <= cmd_byte_d;
            rw_q          <= rw_d;
            dev_q         <= dev_d;
            mem_q         <= mem_d;
            cnt_q         <= cnt_d;
            abyte_q       <= abyte_d;
            err_q         <= err_d;
            retry_q       <= retry_d;
            retry_pend_q  <= retry_pend_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign cmd_valid   = cmd_valid_q;
    assign cmd_start   = cmd_start_q;
    assign cmd_stop    = cmd_stop_q;
    assign cmd_rd      = cmd_rd_q;
    assign cmd_nack    = cmd_nack_q;
    // Write data is taken live from the requester so the consumed byte is the one presented at the handshake.
    assign cmd_wdata   = (state_q == S_WDATA) ? wdata : cmd_byte_q;
    assign wdata_ready = (state_q == S_WDATA) && cmd_valid_q && cmd_ready;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign xfer_done   = (state_q == S_FIN);
    assign xfer_err    = (state_q == S_FIN) && err_q;

endmodule

// File: doc/i2c_xfer_sequencer.md
# i2c_xfer_sequencer

- Sequences complete EEPROM-style transfers onto the byte-level command port of the `i2c_master` core.
- A requester issues one transfer descriptor: device address, register address, direction, length.
- The block then drives the full START / address / data / repeated-START / STOP command chain, ACK/NACK handling and the data byte streams.
- Sits between the system-side requester (CPU register block or DMA) and the `i2c_master` core; it is the only driver of the core's command port.

## Interface
- `ADDR_BYTES`, 2 — register-address bytes sent after the device address (1 or 2; 1 sends only `req_mem_addr[7:0]`).
- `LEN_W`, 4 — width of `req_len`.
- `MAX_RETRY`, 3 — address-phase retries (used only with `I2C_ACK_RETRY_EN`).
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous reset, active-low.
- `req_valid`  in  1  transfer request.
- `req_ready`  out  1  high only in IDLE.
- `req_rw`  in  1  0 = write, 1 = random read.
- `req_dev_addr`  in  8  device address byte; bit0 ignored and replaced by the R/W bit.
- `req_mem_addr`  in  16  register address, MSB byte first.
- `req_len`  in  LEN_W  data byte count; 0 is treated as 1.
- `wdata`  in  8  write byte, sampled when `wdata_ready` is high.
- `wdata_ready`  out  1  one-cycle pulse when a write byte is consumed.
- `rdata`  out  8  received byte.
- `rdata_valid`  out  1  one-cycle pulse; no backpressure.
- `xfer_done`  out  1  one-cycle pulse at transfer end.
- `xfer_err`  out  1  valid with `xfer_done`; 1 = NACK abort.
- `cmd_valid`  out  1  command to core.
- `cmd_ready`  in  1  core idle and accepting.
- `cmd_start`  out  1  generate START (repeated START if the bus is held).
- `cmd_stop`  out  1  generate STOP after this byte; may also be issued alone.
- `cmd_rd`  out  1  1 = read byte, 0 = write byte.
- `cmd_nack`  out  1  master sends NACK after the read byte.
- `cmd_wdata`  out  8  byte to transmit.
- `core_done`  in  1  one-cycle pulse when the commanded byte completes.
- `core_ack`  in  1  slave ACK seen (valid with `core_done` for write bytes).
- `core_rdata`  in  8  received byte (valid with `core_done`).

## Operation
- States: IDLE, DEV_W, MADDR, WDATA, DEV_R, RDATA, STOP, FIN.
- IDLE:
  - `req_valid & req_ready` latches all `req_*` fields.
  - Byte counter loads `max(req_len,1)`.
  - Next state is DEV_W.
- DEV_W: START + write `{dev[7:1],0}`.
  - ACK → MADDR.
  - NACK → STOP with error flagged.
- MADDR: writes `ADDR_BYTES` bytes, high byte first. NACK on any byte → STOP with error.
  - After the last byte, write transfers → WDATA.
  - After the last byte, read transfers → DEV_R.
- WDATA:
  - Each command sends the current `wdata`; `wdata_ready` pulses on the same cycle as the command transfer.
  - `cmd_stop` is set on the final byte.
  - NACK on any byte → STOP with error, remaining bytes not consumed.
  - ACK on the final byte → FIN.
- DEV_R: repeated START + write `{dev[7:1],1}`.
  - ACK → RDATA.
  - NACK → STOP with error.
- RDATA:
  - Each `core_done` pulses `rdata_valid` with `rdata = core_rdata`.
  - Final byte is issued with `cmd_nack=1` and `cmd_stop=1`; all other bytes with `cmd_nack=0`.
  - After the final `core_done` → FIN.
- STOP: issues a stop-only command (`cmd_start=0`, `cmd_stop=1`, no byte), then → FIN on `core_done`.
- FIN: pulses `xfer_done` (with `xfer_err`), then → IDLE.
- Error flag clears when a new request is accepted.

## Timing
- Reset (`rst_n` low at a `clk` edge):
  - State is IDLE.
  - `req_ready=1`.
  - `cmd_valid`, `cmd_start`, `cmd_stop`, `cmd_rd`, `cmd_nack`, `wdata_ready`, `rdata_valid`, `xfer_done`, `xfer_err` are all 0.
  - `cmd_wdata=0`, `rdata=0`.
- Reset mid-transfer:
  - Abandons immediately; no STOP is emitted.
  - The `i2c_master` core shares `rst_n`.
- Command handshake:
  - `cmd_valid` rises on the cycle after state entry.
  - Command fields stay stable until `cmd_valid & cmd_ready`, then `cmd_valid` drops.
  - The block waits for `core_done`; `core_done` is ignored while `cmd_valid` is high.
  - Exactly one outstanding command at a time.
- Request handshake:
  - `req_ready` is 0 from the acceptance cycle through the FIN cycle.
  - `req_ready` is 1 again on the cycle after `xfer_done`.
- Latency:
  - Acceptance → first `cmd_valid` is 2 cycles.
  - `core_done` → next `cmd_valid` is 1 cycle.
  - Last `core_done` → `xfer_done` is 1 cycle (or via STOP).
- A `core_ack` value received with a read byte is ignored.

## Configuration
- `I2C_ACK_RETRY_EN` defined:
  - A NACK in DEV_W (not DEV_R) issues STOP, then restarts DEV_W.
  - Up to `MAX_RETRY` retries; this covers EEPROM write-cycle ACK polling.
  - Error is flagged only once retries are exhausted.
  - The retry counter resets on each accepted request.
- Undefined: any NACK in DEV_W aborts at once; `MAX_RETRY` is unused.

## Test plan
- Random read:
  - Stimulus: rw=1, dev=0xA0, mem=0x1234, len=1.
  - Response: commands `START+0xA0`, `0x12`, `0x34`, `rSTART+0xA1`, `read(nack,stop)`.
  - Slave returns 0xAC → one `rdata_valid` with 0xAC, then `xfer_done`, err=0.
- Burst read:
  - Stimulus: len=8, slave bytes 0x11..0x88.
  - Response: eight `rdata_valid` pulses in order 11,22,…,88; only the 8th command has `cmd_nack=1` and `cmd_stop=1`.
- Writes:
  - rw=0, dev=0xB0, mem=0x0000, len=1, wdata=0xD2 → bytes B0,00,00,D2 with stop on D2; one `wdata_ready` pulse.
  - Then len=3, data AA,0A,A0 → three `wdata_ready` pulses; `xfer_done` err=0.
- Data NACK: slave NACKs the 2nd data byte of len=3 → stop-only command, `xfer_done` err=1, exactly 2 `wdata_ready` pulses.
- Device NACK / retry:
  - Without macro: NACK on 0xA0 → STOP, err=1, no MADDR command.
  - With macro: NACK twice then ACK → 3 DEV_W attempts, err=0.
- Reset mid-burst: `rst_n` low during RDATA byte 4 → next cycle `cmd_valid=0`, `req_ready=1`, no `xfer_done`. A new request completes normally.
